// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART echo path.
// UART_ECHO_PARITY_EN adds the even-parity states to both FSM enums.
package uart_pkg;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_ECHO_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_ECHO_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  // Even parity over up to 9 payload bits; callers zero-extend narrower data.
  function automatic logic parity_of(input logic [8:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and first-word-fall-through read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// UART receiver -> FIFO -> UART transmitter echo engine, single clock domain.
// Define UART_ECHO_PARITY_EN to add an even-parity bit to both directions.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          hwclk,
  input  logic                          rst_n,
  input  logic                          ftdi_rx,
  output logic                          ftdi_tx,
  input  logic                          tx_hold,
  output logic                          led1,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CPB_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  logic rx_s1, rx_s2;

  rx_state_t            rx_state, rx_state_n;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [3:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sr, rx_sr_n;
  logic                 rx_par_ok;
  logic                 push, ferr_set;

  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sr, tx_sr_n;
  logic                 tx_end, tx_line_n, start_ok, pop;

  logic [DATA_BITS-1:0] rdata;
  logic                 full, empty;

`ifdef UART_ECHO_PARITY_EN
  logic rx_par, rx_par_n, tx_par, tx_par_n;
  assign rx_par_ok = (parity_of(9'(rx_sr)) == rx_par);
`else
  assign rx_par_ok = 1'b1;
`endif

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (hwclk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (rx_sr),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Receiver: counter restarts at each sample so later samples stay mid-bit.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_sr_n    = rx_sr;
    push       = 1'b0;
    ferr_set   = 1'b0;
`ifdef UART_ECHO_PARITY_EN
    rx_par_n   = rx_par;
`endif
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_s2 == START_LEVEL) rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt == HALF_M1) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = (rx_s2 == START_LEVEL) ? RX_DATA : RX_IDLE;
      end
      RX_DATA: if (rx_cnt == CPB_M1) begin
        rx_cnt_n = '0;
        rx_sr_n  = {rx_s2, rx_sr[DATA_BITS-1:1]};
        rx_bit_n = rx_bit + 1'b1;
`ifdef UART_ECHO_PARITY_EN
        if (rx_bit == LAST_BIT) rx_state_n = RX_PARITY;
`else
        if (rx_bit == LAST_BIT) rx_state_n = RX_STOP;
`endif
      end
`ifdef UART_ECHO_PARITY_EN
      RX_PARITY: if (rx_cnt == CPB_M1) begin
        rx_cnt_n   = '0;
        rx_par_n   = rx_s2;
        rx_state_n = RX_STOP;
      end
`endif
      RX_STOP: if (rx_cnt == CPB_M1) begin
        rx_cnt_n   = '0;
        rx_state_n = RX_IDLE;
        if (rx_s2 == IDLE_LEVEL && rx_par_ok) push     = 1'b1;
        else                                  ferr_set = 1'b1;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign start_ok = !empty && !tx_hold;

  // Transmitter: the end of a stop bit doubles as an idle decision point so
  // queued bytes go out back-to-back.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_sr_n    = tx_sr;
    pop        = 1'b0;
    tx_end     = (tx_cnt == CPB_M1);
`ifdef UART_ECHO_PARITY_EN
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (start_ok) begin
          pop        = 1'b1;
          tx_state_n = TX_START;
        end
      end
      TX_START: if (tx_end) begin
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_state_n = TX_DATA;
      end
      TX_DATA: if (tx_end) begin
        tx_cnt_n = '0;
        tx_sr_n  = tx_sr >> 1;
        tx_bit_n = tx_bit + 1'b1;
`ifdef UART_ECHO_PARITY_EN
        if (tx_bit == LAST_BIT) tx_state_n = TX_PARITY;
`else
        if (tx_bit == LAST_BIT) tx_state_n = TX_STOP;
`endif
      end
`ifdef UART_ECHO_PARITY_EN
      TX_PARITY: if (tx_end) begin
        tx_cnt_n   = '0;
        tx_state_n = TX_STOP;
      end
`endif
      TX_STOP: if (tx_end) begin
        tx_cnt_n = '0;
        if (start_ok) begin
          pop        = 1'b1;
          tx_state_n = TX_START;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (pop) begin
      tx_sr_n  = rdata;
`ifdef UART_ECHO_PARITY_EN
      tx_par_n = parity_of(9'(rdata));
`endif
    end
    case (tx_state_n)
      TX_START:  tx_line_n = START_LEVEL;
      TX_DATA:   tx_line_n = tx_sr_n[0];
`ifdef UART_ECHO_PARITY_EN
      TX_PARITY: tx_line_n = tx_par_n;
`endif
      default:   tx_line_n = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      rx_s1     <= IDLE_LEVEL;
      rx_s2     <= IDLE_LEVEL;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sr     <= '0;
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sr     <= '0;
      ftdi_tx   <= IDLE_LEVEL;
      led1      <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
      rx_par    <= 1'b0;
      tx_par    <= 1'b0;
`endif
    end else begin
      rx_s1    <= ftdi_rx;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sr    <= rx_sr_n;
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sr    <= tx_sr_n;
      ftdi_tx  <= tx_line_n;
`ifdef UART_ECHO_PARITY_EN
      rx_par   <= rx_par_n;
      tx_par   <= tx_par_n;
`endif
      if (push && (!full || pop)) led1      <= ~led1;
      if (push && full && !pop)   overflow  <= 1'b1;
      if (ferr_set)               frame_err <= 1'b1;
    end
  end

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Parametrised UART echo engine for the FTDI serial link. It holds an integrated 8N1-style receiver and transmitter with configurable bit timing and data width, and a synchronous FIFO between them, so back-to-back received characters are buffered and echoed in order instead of being lost. The block sits at the top of the serial path in place of the single-byte echo and drives the status LED plus error flags. Everything runs in one clock domain.

## Interface
Parameters:
- CLKS_PER_BIT, default 1250: hwclk cycles per UART bit (12 MHz / 9600 baud); must be at least 4.
- DATA_BITS, default 8: payload bits per frame, range 5..9.
- FIFO_DEPTH, default 16: FIFO entries; must be a power of two, at least 2.

Ports:
- Clock and reset: one clock, `hwclk`; reset is synchronous and active-low, `rst_n`.
- hwclk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- ftdi_rx  in  1  UART receive line; asynchronous, idle high.
- ftdi_tx  out  1  UART transmit line; idle high.
- tx_hold  in  1  when high, the TX side starts no new frame. A frame already in progress completes.
- led1  out  1  toggles once per byte accepted into the FIFO.
- overflow  out  1  sticky flag; a received byte was dropped because the FIFO was full.
- frame_err  out  1  sticky flag; stop bit sampled low, or a parity mismatch when parity is compiled in.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset (rst_n low at a clock edge) puts the outputs in this state: ftdi_tx=1, led1=0, overflow=0, frame_err=0, fifo_level=0.
- Reset also clears the FIFO pointers, returns both FSMs to IDLE, and sets the synchroniser flops to 1.
- Reset mid-frame abandons the frame. ftdi_tx is high on the cycle after the reset edge.
- **RX input:** ftdi_rx passes through a 2-flop synchroniser.
- **RX FSM states:** RX_IDLE → RX_START → RX_DATA → [RX_PARITY] → RX_STOP → RX_IDLE.
  - RX_IDLE: a synchronised low moves the FSM to RX_START.
  - RX_START: samples the line at CLKS_PER_BIT/2. If the line is high again (glitch), return to RX_IDLE with no error.
  - RX_DATA: samples at every CLKS_PER_BIT, LSB first, DATA_BITS samples.
  - RX_STOP: samples the stop bit. If it is 1 and parity is OK, the byte is valid. Otherwise set frame_err and discard the byte.
- **RX to FIFO:** a valid byte produces a one-cycle push.
  - FIFO not full: the byte is written and led1 toggles.
  - FIFO full: the byte is dropped, overflow is set, led1 does not toggle.
  - Push and pop in the same cycle on a full FIFO: both happen, no overflow.
- **TX FSM states:** TX_IDLE → TX_START → TX_DATA → [TX_PARITY] → TX_STOP → TX_IDLE. Each state lasts CLKS_PER_BIT cycles.
  - In TX_IDLE with FIFO not empty and tx_hold=0, the FSM pops one entry and enters TX_START.
  - tx_hold is checked only in TX_IDLE.
- FIFO pointers carry an extra wrap bit. full = (pointer MSBs differ) AND (remaining bits equal).
- fifo_level = wr_ptr − rd_ptr, modulo 2^(width). It saturates naturally at FIFO_DEPTH.
- overflow and frame_err clear only on reset.

## Timing
- RX sample points fall at CLKS_PER_BIT/2 + k·CLKS_PER_BIT cycles after the synchronised start edge. The synchroniser adds 2 cycles of latency.
- The FIFO push occurs on the cycle of the stop-bit sample (cycle N). fifo_level increments at N+1.
- With the FIFO empty, TX idle and tx_hold=0: the pop happens at N+1, and ftdi_tx goes low at N+2. Echo latency is therefore 2 cycles after the stop sample.
- TX frame length is (2 + DATA_BITS [+1 with parity]) × CLKS_PER_BIT cycles.
- A new TX frame can start on the cycle immediately after the stop bit ends. This allows continuous back-to-back transmission.
- The RX FSM returns to RX_IDLE right after the mid-stop sample, so it can catch a start bit that follows immediately.

## Configuration
- Macro: UART_ECHO_PARITY_EN.
- Defined: RX and TX each add one even-parity bit after the data bits. An RX parity mismatch sets frame_err and drops the byte.
- Undefined: no parity states exist, and frames are start + DATA_BITS + stop.

## Structure
- Shared package uart_pkg holds:
  - rx_state_t and tx_state_t enums.
  - The IDLE_LEVEL=1'b1 and START_LEVEL=1'b0 constants.
  - A parity function.
- Sub-module sync_fifo, parameterised by WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, level.
  - Read is first-word-fall-through.
- The RX and TX FSMs live in uart_echo_fifo.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4.
- **Single echo:** drive frame 0x55 on ftdi_rx. Expect ftdi_tx low 2 cycles after the stop sample, then an identical 0x55 frame; led1 toggles 0→1; fifo_level returns to 0.
- **Burst with hold:** set tx_hold=1 and send 0x01..0x04. Expect fifo_level=4 and no overflow. Release tx_hold; expect 0x01, 0x02, 0x03, 0x04 echoed back-to-back with no idle gap.
- **Overflow:** with tx_hold=1 and 4 bytes queued, send 0xAA. Expect overflow=1, fifo_level=4, led1 unchanged, and 0xAA never transmitted.
- **Framing:** send 0x3C with the stop bit driven low. Expect frame_err=1, no push, ftdi_tx stays high.
- **Glitch and reset:** a 1-cycle low pulse on ftdi_rx produces no push and no error. Asserting rst_n=0 mid-TX frame gives ftdi_tx=1 on the next cycle, all flags 0, fifo_level=0.
- **Parity (UART_ECHO_PARITY_EN defined):** 0x07 sent with parity bit 0 gives frame_err=1; sent with parity bit 1, it is echoed with parity bit 1.
